// File: rtl/restrict_env_driver.sv
// restrict_env_driver: stimulus-side driver for the restrict-property consumer.
// Sequences the consumer's reset_n/debug_mode/test_mode so that reset_n_out=1
// only ever coincides with debug_mode=1 and test_mode=0, and plays
// restrict_cond bursts requested on the command port.
// Optional feature macro: RESTRICT_ENV_DRV_CHECK_EN (restrict_out feedback
// checking; when undefined mismatch_cnt is tied to zero).
// cmd_ready is registered, so it reflects test_req one cycle late; a command
// presented while test_req is high is never taken (test_req wins).
module restrict_env_driver #(
  parameter int unsigned RESET_HOLD = 4,
  parameter int unsigned SETTLE     = 2,
  parameter int unsigned LEN_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             test_req,
  input  logic             restrict_out,
  output logic             reset_n_out,
  output logic             debug_mode,
  output logic             test_mode,
  output logic             restrict_cond,
  output logic             busy,
  output logic [15:0]      mismatch_cnt
);

  localparam int unsigned CNT_MAX = (RESET_HOLD > SETTLE) ? RESET_HOLD : SETTLE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_SETTLE,
    S_RUN,
    S_T_ENTER,
    S_TEST,
    S_T_EXIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;        // cycles spent in the current timed state
  logic [LEN_W-1:0] burst_rem;  // restrict_cond cycles left after the current one

  // Sequencing FSM with all consumer-facing outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_HOLD;
      cnt           <= '0;
      burst_rem     <= '0;
      reset_n_out   <= 1'b0;
      debug_mode    <= 1'b0;
      test_mode     <= 1'b0;
      restrict_cond <= 1'b0;
      cmd_ready     <= 1'b0;
      busy          <= 1'b1;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == CNT_W'(RESET_HOLD)) begin
            state      <= S_SETTLE;
            cnt        <= CNT_W'(1);
            debug_mode <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (cnt == CNT_W'(SETTLE)) begin
            state       <= S_RUN;
            reset_n_out <= 1'b1;
            cmd_ready   <= !test_req;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (restrict_cond) begin
            // burst in flight: finish it before anything else
            if (burst_rem == '0) begin
              restrict_cond <= 1'b0;
              cmd_ready     <= !test_req;
              busy          <= 1'b0;
            end else begin
              burst_rem <= burst_rem - LEN_W'(1);
            end
          end else if (test_req) begin
            state       <= S_T_ENTER;
            reset_n_out <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
          end else begin
            cmd_ready <= 1'b1;
            // zero-length commands are accepted but produce no pulse
            if (cmd_valid && cmd_ready && (cmd_len != '0)) begin
              restrict_cond <= 1'b1;
              burst_rem     <= cmd_len - LEN_W'(1);
              cmd_ready     <= 1'b0;
              busy          <= 1'b1;
            end
          end
        end
        S_T_ENTER: begin
          state     <= S_TEST;
          test_mode <= 1'b1;
        end
        S_TEST: begin
          if (!test_req) begin
            state     <= S_T_EXIT;
            test_mode <= 1'b0;
            cnt       <= CNT_W'(1);
          end
        end
        S_T_EXIT: begin
          if (cnt == CNT_W'(SETTLE)) begin
            state       <= S_RUN;
            reset_n_out <= 1'b1;
            cmd_ready   <= !test_req;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef RESTRICT_ENV_DRV_CHECK_EN
  logic exp_restrict;
  assign exp_restrict = restrict_cond & debug_mode & !test_mode;

  // Count RUN cycles where the consumer's feedback disagrees with what we drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_cnt <= '0;
    end else if ((state == S_RUN) && (restrict_out != exp_restrict) &&
                 (mismatch_cnt != 16'hFFFF)) begin
      mismatch_cnt <= mismatch_cnt + 16'd1;
    end
  end
`else
  // Feedback is ignored when checking is compiled out
  logic unused_restrict_out;
  assign unused_restrict_out = restrict_out;
  assign mismatch_cnt        = '0;
`endif

endmodule
